ark_stage: RTL and testbench

ARK_STAGE -- requirements
Module: ark_stage

---
 rtl/ark_stage.sv | 87 ++++++++
 tb/tb_ark_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ark_stage.sv
// ark_stage: AddRoundKey stage with a round-key store, write bypass and a single-register output
module ark_stage #(
   parameter int DATA_W   = 128,
   parameter int NUM_KEYS = 11,
   parameter int KIDX_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_we,
   input  logic [KIDX_W-1:0] key_waddr,
   input  logic [DATA_W-1:0] key_wdata,
   input  logic              key_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KIDX_W-1:0] in_kidx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [KIDX_W-1:0] out_kidx,
   output logic              out_err
);
   logic [DATA_W-1:0]   r_key [NUM_KEYS];
   logic [NUM_KEYS-1:0] r_kval;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic [KIDX_W-1:0]   r_kidx;
   logic                r_err;
   logic [NUM_KEYS-1:0] w_we;
   logic [DATA_W-1:0]   w_key;
   logic                w_kv;
   logic                w_in_xfer;

   assign in_ready  = !rst && (!r_valid || out_ready);
   assign w_in_xfer = in_valid && in_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_kidx  = r_kidx;
   assign out_err   = r_err;

   // Decode slot writes and select the key for in_kidx, resolving clear then same-cycle write
   always_comb begin
      w_we  = '0;
      w_key = '0;
      w_kv  = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         w_we[k] = key_we && (key_waddr == KIDX_W'(k));
         if (in_kidx == KIDX_W'(k)) begin
            w_key = w_we[k] ? key_wdata : r_key[k];
            w_kv  = w_we[k] || (r_kval[k] && !key_clr);
         end
      end
   end

   // Key store: clear drops valid bits only, a write in the same cycle wins for its slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kval <= '0;
         for (int k = 0; k < NUM_KEYS; k++) r_key[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_clr) r_kval[k] <= 1'b0;
            if (w_we[k]) begin
               r_key[k]  <= key_wdata;
               r_kval[k] <= 1'b1;
            end
         end
      end
   end

   // Output register: loads only on an input transfer, empties when drained without refill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_kidx  <= '0;
         r_err   <= 1'b0;
      end else if (w_in_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_kv ? (in_data ^ w_key) : in_data;
         r_kidx  <= in_kidx;
         r_err   <= !w_kv;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ark_stage.sv
// tb_ark_stage: directed self-checking bench for ark_stage
module tb_ark_stage;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_we = 1'b0;
   logic [3:0]   key_waddr = '0;
   logic [127:0] key_wdata = '0;
   logic         key_clr = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [3:0]   in_kidx = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic [3:0]   out_kidx;
   logic         out_err;
   int           n_chk = 0;
   int           n_fail = 0;
   logic [127:0] held;

   ark_stage dut (
      .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
      .key_clr(key_clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_kidx(in_kidx), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_kidx(out_kidx), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] key_of(input int k);
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(16 * k + i);
      return v;
   endfunction

   function automatic logic [127:0] dat_of(input int i);
      return {4{32'(i + 1) * 32'h9E3779B1}};
   endfunction

   initial begin
      // reset state, key write during reset must be ignored
      key_we = 1'b1; key_waddr = 4'd5; key_wdata = key_of(5);
      tick(); tick();
      chk("rst_valid", 128'(out_valid), 128'd0);
      chk("rst_data", out_data, 128'd0);
      chk("rst_kidx", 128'(out_kidx), 128'd0);
      chk("rst_err", 128'(out_err), 128'd0);
      chk("rst_ready", 128'(in_ready), 128'd0);
      key_we = 1'b0;
      rst = 1'b0;
      #1 chk("post_rst_ready", 128'(in_ready), 128'd1);
      // slot 5 was written only during reset, so it must still be invalid
      in_valid = 1'b1; in_kidx = 4'd5; in_data = 128'h1234; out_ready = 1'b1;
      tick();
      chk("rstwe_err", 128'(out_err), 128'd1);
      chk("rstwe_data", out_data, 128'h1234);
      in_valid = 1'b0;
      // known-answer vector with key 0
      key_we = 1'b1; key_waddr = 4'd0; key_wdata = key_of(0);
      tick();
      key_we = 1'b0;
      in_valid = 1'b1; in_data = 128'h00112233445566778899AABBCCDDEEFF; in_kidx = 4'd0;
      tick();
      in_valid = 1'b0;
      chk("kat_valid", 128'(out_valid), 128'd1);
      chk("kat_data", out_data, 128'h00102030405060708090A0B0C0D0E0F0);
      chk("kat_err", 128'(out_err), 128'd0);
      chk("kat_kidx", 128'(out_kidx), 128'd0);
      tick();
      chk("drain_valid", 128'(out_valid), 128'd0);
      // load remaining keys, plus ignored writes to out-of-range slots
      for (int k = 1; k <= 10; k++) begin
         key_we = 1'b1; key_waddr = 4'(k); key_wdata = key_of(k);
         tick();
      end
      key_waddr = 4'd11; key_wdata = '1;
      tick();
      key_waddr = 4'd15;
      tick();
      key_we = 1'b0;
      // back-to-back at full throughput
      for (int i = 0; i <= 10; i++) begin
         in_valid = 1'b1; in_data = dat_of(i); in_kidx = 4'(i);
         #1 chk($sformatf("b2b_ready%0d", i), 128'(in_ready), 128'd1);
         tick();
         chk($sformatf("b2b_valid%0d", i), 128'(out_valid), 128'd1);
         chk($sformatf("b2b_data%0d", i), out_data, dat_of(i) ^ key_of(i));
         chk($sformatf("b2b_kidx%0d", i), 128'(out_kidx), 128'(i));
         chk($sformatf("b2b_err%0d", i), 128'(out_err), 128'd0);
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_end_valid", 128'(out_valid), 128'd0);
      // backpressure: result held 5 cycles, next item waits, key rewrite must not disturb it
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 128'hA5A5; in_kidx = 4'd2;
      tick();
      held = 128'hA5A5 ^ key_of(2);
      in_data = 128'h5A5A; in_kidx = 4'd4;
      key_we = 1'b1; key_waddr = 4'd2; key_wdata = key_of(2);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("bp_ready%0d", j), 128'(in_ready), 128'd0);
         chk($sformatf("bp_valid%0d", j), 128'(out_valid), 128'd1);
         chk($sformatf("bp_data%0d", j), out_data, held);
         chk($sformatf("bp_kidx%0d", j), 128'(out_kidx), 128'd2);
         tick();
      end
      key_we = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_next_valid", 128'(out_valid), 128'd1);
      chk("bp_next_data", out_data, 128'h5A5A ^ key_of(4));
      chk("bp_next_kidx", 128'(out_kidx), 128'd4);
      in_valid = 1'b0;
      tick();
      chk("bp_end_valid", 128'(out_valid), 128'd0);
      // out-of-range index
      in_valid = 1'b1; in_data = 128'hE0E1E2; in_kidx = 4'd11;
      tick();
      chk("oor_data", out_data, 128'hE0E1E2);
      chk("oor_err", 128'(out_err), 128'd1);
      chk("oor_kidx", 128'(out_kidx), 128'd11);
      // invalid slot after clear
      in_valid = 1'b0; key_clr = 1'b1;
      tick();
      key_clr = 1'b0;
      in_valid = 1'b1; in_data = 128'hF00D; in_kidx = 4'd3;
      tick();
      chk("clr_data", out_data, 128'hF00D);
      chk("clr_err", 128'(out_err), 128'd1);
      // same-cycle write bypass
      key_we = 1'b1; key_waddr = 4'd3; key_wdata = 128'h0F0F_0000_FFFF;
      in_data = 128'hBEEF_0123;
      tick();
      key_we = 1'b0;
      chk("byp_data", out_data, 128'hBEEF_0123 ^ 128'h0F0F_0000_FFFF);
      chk("byp_err", 128'(out_err), 128'd0);
      // slot 3 now stays valid
      in_data = 128'h77;
      tick();
      chk("kept_data", out_data, 128'h77 ^ 128'h0F0F_0000_FFFF);
      chk("kept_err", 128'(out_err), 128'd0);
      // asynchronous reset while a result is held
      in_valid = 1'b0; out_ready = 1'b0;
      chk("ar_pre_valid", 128'(out_valid), 128'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 128'(out_valid), 128'd0);
      chk("ar_data", out_data, 128'd0);
      chk("ar_err", 128'(out_err), 128'd0);
      chk("ar_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_data = 128'hC0DE; in_kidx = 4'd3; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ar_first_valid", 128'(out_valid), 128'd1);
      chk("ar_first_data", out_data, 128'hC0DE);
      chk("ar_first_err", 128'(out_err), 128'd1);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
